// File: rtl/ysyx_24100029_wb_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_24100029_wb_pkg
// Shared constants and types for the write-back stage.
//   - CSR_* : bit positions of the csr_wen write-enable vector
//   - ECALL_INST / MCAUSE_ECALL : ecall encoding and its machine cause code
//   - MSTATUS_RESET : mstatus value after reset (MPP = machine mode)
//   - wb_hold_t : contents of the single-entry hold register
// ----------------------------------------------------------------------------
package ysyx_24100029_wb_pkg;

    localparam int CSR_MSTATUS = 0;
    localparam int CSR_MTVEC   = 1;
    localparam int CSR_MEPC    = 2;
    localparam int CSR_MCAUSE  = 3;

    localparam logic [31:0] ECALL_INST    = 32'h0000_0073;
    localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;
    localparam logic [31:0] MCAUSE_ECALL  = 32'd11;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] wdata;    // already resolved: load data or execute result
        logic [4:0]  rd;
        logic        r_wen;
        logic [3:0]  csr_wen;
        logic [31:0] csrs;
        logic        jump;
    } wb_hold_t;

endpackage

// File: rtl/ysyx_24100029_RegisterFile.sv
// ----------------------------------------------------------------------------
// ysyx_24100029_RegisterFile
// Integer register file: NR_REG x 32 bits, one synchronous write port and two
// asynchronous read ports. Register x0 is never written and always reads 0.
// Ports:
//   clock, reset        : clock, asynchronous active-high reset (clears all)
//   we, waddr, wdata    : write port
//   raddr1/rdata1       : read port 1 (combinational)
//   raddr2/rdata2       : read port 2 (combinational)
// ----------------------------------------------------------------------------
module ysyx_24100029_RegisterFile #(
    parameter int NR_REG = 32,
    localparam int AW    = $clog2(NR_REG)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr1,
    output logic [31:0]   rdata1,
    input  logic [AW-1:0] raddr2,
    output logic [31:0]   rdata2
);

    logic [31:0] regs [NR_REG];

    // NOTE: this array is reset because every GPR must read zero after reset;
    // it therefore maps to flops, not to a RAM macro (RAMs cannot be reset).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NR_REG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/ysyx_24100029_wbu.sv
// ----------------------------------------------------------------------------
// ysyx_24100029_wbu
// Write-back stage. Holds one retired instruction from the load/store stage,
// presents it on the commit handshake, and on retirement writes the GPR file,
// the machine CSRs and bumps minstret. Decode reads the GPRs through two
// combinational ports that bypass the held (not yet retired) result.
// Ports:
//   clock, reset                  : clock, asynchronous active-high reset
//   valid_last / ready_last       : upstream handshake
//   pc, inst, R_wen, rd, mem_ren,
//   LSU_Rdata, Ex_result, csr_wen,
//   csrs, jump_flag               : instruction payload from load/store stage
//   commit_valid / commit_ready   : retirement handshake
//   commit_pc/inst/jump           : held instruction, stable until retired
//   raddr1/rdata1, raddr2/rdata2  : forwarded GPR read ports for decode
//   mtvec_o, mepc_o               : architectural mtvec / mepc
//   minstret                      : 64-bit retired-instruction counter
// ----------------------------------------------------------------------------
module ysyx_24100029_wbu
    import ysyx_24100029_wb_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          NR_REG   = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_last,
    output logic        ready_last,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic        R_wen,
    input  logic [4:0]  rd,
    input  logic        mem_ren,
    input  logic [31:0] LSU_Rdata,
    input  logic [31:0] Ex_result,
    input  logic [3:0]  csr_wen,
    input  logic [31:0] csrs,
    input  logic        jump_flag,
    output logic        commit_valid,
    input  logic        commit_ready,
    output logic [31:0] commit_pc,
    output logic [31:0] commit_inst,
    output logic        commit_jump,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic [63:0] minstret
);

    localparam int AW = $clog2(NR_REG);

    wb_hold_t    hold;
    wb_hold_t    hold_next;
    logic        capture;
    logic        retire;
    logic        is_ecall;
    logic        gpr_we;
    logic [31:0] gpr_rdata1;
    logic [31:0] gpr_rdata2;

    logic [31:0] mstatus;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;

    // The hold register frees up in the same cycle it retires, giving
    // one instruction per cycle under continuous commit_ready.
    assign ready_last = ~commit_valid | commit_ready;
    assign capture    = valid_last & ready_last;
    assign retire     = commit_valid & commit_ready;
    assign is_ecall   = (hold.inst == ECALL_INST);
    assign gpr_we     = retire & hold.r_wen & (hold.rd != 5'd0);

    // NOTE: every field is assigned in this one statement, so no path can
    // leave hold_next unassigned and no latch is inferred.
    always_comb begin
        hold_next = '{
            pc:      pc,
            inst:    inst,
            wdata:   mem_ren ? LSU_Rdata : Ex_result,
            rd:      rd,
            r_wen:   R_wen,
            csr_wen: csr_wen,
            csrs:    csrs,
            jump:    jump_flag
        };
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            commit_valid <= 1'b0;
            hold         <= '{pc: RESET_PC, default: '0};
        end else if (capture) begin
            commit_valid <= 1'b1;
            hold         <= hold_next;
        end else if (retire) begin
            commit_valid <= 1'b0;
        end
    end

    // CSR commit; an ecall's mepc/mcause update overrides explicit writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mstatus  <= MSTATUS_RESET;
            mtvec    <= '0;
            mepc     <= '0;
            mcause   <= '0;
            minstret <= '0;
        end else if (retire) begin
            if (hold.csr_wen[CSR_MSTATUS]) mstatus <= hold.csrs;
            if (hold.csr_wen[CSR_MTVEC])   mtvec   <= hold.csrs;
            if (is_ecall) begin
                mepc   <= hold.pc;
                mcause <= MCAUSE_ECALL;
            end else begin
                if (hold.csr_wen[CSR_MEPC])   mepc   <= hold.csrs;
                if (hold.csr_wen[CSR_MCAUSE]) mcause <= hold.csrs;
            end
            minstret <= minstret + 64'd1;
        end
    end

    ysyx_24100029_RegisterFile #(
        .NR_REG (NR_REG)
    ) u_regfile (
        .clock  (clock),
        .reset  (reset),
        .we     (gpr_we),
        .waddr  (hold.rd[AW-1:0]),
        .wdata  (hold.wdata),
        .raddr1 (raddr1[AW-1:0]),
        .rdata1 (gpr_rdata1),
        .raddr2 (raddr2[AW-1:0]),
        .rdata2 (gpr_rdata2)
    );

    // Bypass the held result whether or not it retires this cycle, so decode
    // never sees a stale value for a register about to be written.
    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 :
                    (commit_valid && hold.r_wen && hold.rd == raddr1) ? hold.wdata :
                    gpr_rdata1;
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 :
                    (commit_valid && hold.r_wen && hold.rd == raddr2) ? hold.wdata :
                    gpr_rdata2;

    assign commit_pc   = hold.pc;
    assign commit_inst = hold.inst;
    assign commit_jump = hold.jump;
    assign mtvec_o     = mtvec;
    assign mepc_o      = mepc;

endmodule

// File: tb/tb_ysyx_24100029_wbu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_24100029_wbu
// Directed, table-driven bench for the write-back stage: single-instruction
// vectors with hand-computed results, plus hand-written back-pressure and
// reset-mid-hold sequences.
// ----------------------------------------------------------------------------
module tb_ysyx_24100029_wbu;

    logic        clock;
    logic        reset;
    logic        valid_last;
    logic        ready_last;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        R_wen;
    logic [4:0]  rd;
    logic        mem_ren;
    logic [31:0] LSU_Rdata;
    logic [31:0] Ex_result;
    logic [3:0]  csr_wen;
    logic [31:0] csrs;
    logic        jump_flag;
    logic        commit_valid;
    logic        commit_ready;
    logic [31:0] commit_pc;
    logic [31:0] commit_inst;
    logic        commit_jump;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic [63:0] minstret;

    int n_cmp = 0;
    int n_err = 0;

    ysyx_24100029_wbu dut (
        .clock        (clock),
        .reset        (reset),
        .valid_last   (valid_last),
        .ready_last   (ready_last),
        .pc           (pc),
        .inst         (inst),
        .R_wen        (R_wen),
        .rd           (rd),
        .mem_ren      (mem_ren),
        .LSU_Rdata    (LSU_Rdata),
        .Ex_result    (Ex_result),
        .csr_wen      (csr_wen),
        .csrs         (csrs),
        .jump_flag    (jump_flag),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_pc    (commit_pc),
        .commit_inst  (commit_inst),
        .commit_jump  (commit_jump),
        .raddr1       (raddr1),
        .rdata1       (rdata1),
        .raddr2       (raddr2),
        .rdata2       (rdata2),
        .mtvec_o      (mtvec_o),
        .mepc_o       (mepc_o),
        .minstret     (minstret)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        r_wen;
        logic [4:0]  rd;
        logic        mem_ren;
        logic [31:0] lsu;
        logic [31:0] ex;
        logic [3:0]  csr_wen;
        logic [31:0] csrs;
        logic        jump;
        logic [31:0] exp_byp;     // rdata at rd while held (before retire)
        logic [31:0] exp_gpr;     // rdata at rd after retire
        logic [31:0] exp_mtvec;   // after retire
        logic [31:0] exp_mepc;    // after retire
        logic [31:0] exp_mcause;  // after retire
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] p, input logic [31:0] i, input logic w,
                         input logic [4:0] r, input logic mr, input logic [31:0] l,
                         input logic [31:0] e, input logic [3:0] cw, input logic [31:0] cs,
                         input logic j);
        pc = p; inst = i; R_wen = w; rd = r; mem_ren = mr;
        LSU_Rdata = l; Ex_result = e; csr_wen = cw; csrs = cs; jump_flag = j;
    endtask

    initial begin
        logic [31:0] prev_mtvec;
        logic [31:0] prev_mepc;
        logic [63:0] exp_inst_cnt;

        reset = 1'b1;
        valid_last = 1'b0;
        commit_ready = 1'b0;
        raddr1 = 5'd0;
        raddr2 = 5'd0;
        drive(32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);

        //           pc            inst          wen rd    mren lsu           ex            cwen     csrs          jmp   byp           gpr           mtvec         mepc          mcause
        vecs[0] = '{32'h8000_0010, 32'h0000_2283, 1, 5'd5, 1, 32'hFFFF_FF80, 32'h0000_1234, 4'b0000, 32'h0,         0, 32'hFFFF_FF80, 32'hFFFF_FF80, 32'h0,         32'h0,         32'h0};
        vecs[1] = '{32'h8000_0014, 32'h0010_0313, 1, 5'd6, 0, 32'h0000_AAAA, 32'h0000_1234, 4'b0000, 32'h0,         1, 32'h0000_1234, 32'h0000_1234, 32'h0,         32'h0,         32'h0};
        vecs[2] = '{32'h8000_0018, 32'h0000_0013, 1, 5'd0, 0, 32'h0,         32'h0000_DEAD, 4'b0000, 32'h0,         0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0};
        vecs[3] = '{32'h8000_0100, 32'h0000_0073, 0, 5'd0, 0, 32'h0,         32'h0,         4'b1100, 32'h0000_0055, 1, 32'h0,         32'h0,         32'h0,         32'h8000_0100, 32'd11};
        vecs[4] = '{32'h8000_0104, 32'h3052_9073, 0, 5'd0, 0, 32'h0,         32'h0,         4'b0010, 32'h8000_0200, 0, 32'h0,         32'h0,         32'h8000_0200, 32'h8000_0100, 32'd11};
        vecs[5] = '{32'h8000_0108, 32'h3410_9073, 1, 5'd5, 0, 32'h0,         32'h0000_0077, 4'b0100, 32'h8000_0300, 0, 32'h0000_0077, 32'h0000_0077, 32'h8000_0200, 32'h8000_0300, 32'd11};
        vecs[6] = '{32'h8000_010C, 32'h0000_0013, 0, 5'd6, 0, 32'h0,         32'h0000_0999, 4'b0000, 32'h0,         0, 32'h0000_1234, 32'h0000_1234, 32'h8000_0200, 32'h8000_0300, 32'd11};

        // Reset state, observed while reset is still asserted.
        #12;
        check("rst_commit_valid", {63'd0, commit_valid}, 64'd0);
        check("rst_ready_last",   {63'd0, ready_last},   64'd1);
        check("rst_commit_pc",    {32'd0, commit_pc},    64'h8000_0000);
        check("rst_commit_inst",  {32'd0, commit_inst},  64'd0);
        check("rst_commit_jump",  {63'd0, commit_jump},  64'd0);
        check("rst_minstret",     minstret,              64'd0);
        check("rst_mtvec",        {32'd0, mtvec_o},      64'd0);
        check("rst_mepc",         {32'd0, mepc_o},       64'd0);
        check("rst_mstatus",      {32'd0, dut.mstatus},  64'h0000_1800);
        raddr1 = 5'd5;
        #1;
        check("rst_gpr5",         {32'd0, rdata1},       64'd0);
        reset = 1'b0;
        tick();

        // Table-driven single instructions: capture, inspect held state, retire.
        prev_mtvec = 32'h0;
        prev_mepc  = 32'h0;
        exp_inst_cnt = 64'd0;
        for (int k = 0; k < 7; k++) begin
            drive(vecs[k].pc, vecs[k].inst, vecs[k].r_wen, vecs[k].rd, vecs[k].mem_ren,
                  vecs[k].lsu, vecs[k].ex, vecs[k].csr_wen, vecs[k].csrs, vecs[k].jump);
            valid_last = 1'b1;
            commit_ready = 1'b0;
            raddr1 = vecs[k].rd;
            raddr2 = vecs[k].rd;
            tick();
            valid_last = 1'b0;
            #1;
            check($sformatf("v%0d_held_valid", k), {63'd0, commit_valid}, 64'd1);
            check($sformatf("v%0d_held_pc", k),    {32'd0, commit_pc},    {32'd0, vecs[k].pc});
            check($sformatf("v%0d_held_inst", k),  {32'd0, commit_inst},  {32'd0, vecs[k].inst});
            check($sformatf("v%0d_held_jump", k),  {63'd0, commit_jump},  {63'd0, vecs[k].jump});
            check($sformatf("v%0d_bypass", k),     {32'd0, rdata1},       {32'd0, vecs[k].exp_byp});
            check($sformatf("v%0d_pre_mtvec", k),  {32'd0, mtvec_o},      {32'd0, prev_mtvec});
            check($sformatf("v%0d_pre_mepc", k),   {32'd0, mepc_o},       {32'd0, prev_mepc});
            commit_ready = 1'b1;
            tick();
            commit_ready = 1'b0;
            exp_inst_cnt = exp_inst_cnt + 64'd1;
            #1;
            check($sformatf("v%0d_post_valid", k),  {63'd0, commit_valid}, 64'd0);
            check($sformatf("v%0d_gpr_p1", k),      {32'd0, rdata1},       {32'd0, vecs[k].exp_gpr});
            check($sformatf("v%0d_gpr_p2", k),      {32'd0, rdata2},       {32'd0, vecs[k].exp_gpr});
            check($sformatf("v%0d_mtvec", k),       {32'd0, mtvec_o},      {32'd0, vecs[k].exp_mtvec});
            check($sformatf("v%0d_mepc", k),        {32'd0, mepc_o},       {32'd0, vecs[k].exp_mepc});
            check($sformatf("v%0d_mcause", k),      {32'd0, dut.mcause},   {32'd0, vecs[k].exp_mcause});
            check($sformatf("v%0d_minstret", k),    minstret,              exp_inst_cnt);
            prev_mtvec = vecs[k].exp_mtvec;
            prev_mepc  = vecs[k].exp_mepc;
        end

        // Back-pressure: I1 held while I2 is offered for three stalled cycles,
        // then retire + capture in a single edge.
        drive(32'h8000_0200, 32'h0110_0413, 1'b1, 5'd8, 1'b0, 32'h0, 32'h0000_0011, 4'h0, 32'h0, 1'b0);
        valid_last = 1'b1;
        commit_ready = 1'b0;
        tick();
        drive(32'h8000_0204, 32'h0220_0493, 1'b1, 5'd9, 1'b0, 32'h0, 32'h0000_0022, 4'h0, 32'h0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp%0d_ready_last", c), {63'd0, ready_last},   64'd0);
            check($sformatf("bp%0d_valid", c),      {63'd0, commit_valid}, 64'd1);
            check($sformatf("bp%0d_pc", c),         {32'd0, commit_pc},    64'h8000_0200);
            tick();
        end
        commit_ready = 1'b1;
        #1;
        check("bp_ready_on_commit", {63'd0, ready_last}, 64'd1);
        tick();
        valid_last = 1'b0;
        commit_ready = 1'b0;
        raddr1 = 5'd8;
        raddr2 = 5'd9;
        #1;
        check("bp_swap_valid",  {63'd0, commit_valid}, 64'd1);
        check("bp_swap_pc",     {32'd0, commit_pc},    64'h8000_0204);
        check("bp_gpr8",        {32'd0, rdata1},       64'h11);
        check("bp_bypass9",     {32'd0, rdata2},       64'h22);
        check("bp_minstret1",   minstret,              exp_inst_cnt + 64'd1);
        commit_ready = 1'b1;
        tick();
        commit_ready = 1'b0;
        #1;
        check("bp_drain_valid", {63'd0, commit_valid}, 64'd0);
        check("bp_gpr9",        {32'd0, rdata2},       64'h22);
        check("bp_minstret2",   minstret,              exp_inst_cnt + 64'd2);

        // Reset mid-hold: the held write to x7 must be discarded.
        drive(32'h8000_0300, 32'h0770_0393, 1'b1, 5'd7, 1'b0, 32'h0, 32'h0000_0077, 4'b0010, 32'h1234_5678, 1'b1);
        valid_last = 1'b1;
        tick();
        valid_last = 1'b0;
        raddr1 = 5'd7;
        #1;
        check("rh_held_valid", {63'd0, commit_valid}, 64'd1);
        check("rh_bypass7",    {32'd0, rdata1},       64'h77);
        #1;
        reset = 1'b1;
        #1;
        check("rh_valid_cleared", {63'd0, commit_valid}, 64'd0);
        check("rh_ready_last",    {63'd0, ready_last},   64'd1);
        check("rh_commit_pc",     {32'd0, commit_pc},    64'h8000_0000);
        check("rh_minstret",      minstret,              64'd0);
        commit_ready = 1'b1;
        tick();
        reset = 1'b0;
        commit_ready = 1'b0;
        tick();
        check("rh_gpr7",   {32'd0, rdata1},  64'd0);
        check("rh_mtvec",  {32'd0, mtvec_o}, 64'd0);
        check("rh_mepc",   {32'd0, mepc_o},  64'd0);
        check("rh_idle",   {63'd0, commit_valid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
